// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - two-requester round-robin arbiter in front of a shared ALU
// Registers the ALU result, tagged with the requester id, into a single-entry response buffer.
module alu_rr_arbiter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid_0,
   input  logic             req_valid_1,
   output logic             req_ready_0,
   output logic             req_ready_1,
   input  logic [WIDTH-1:0] req_in1_0,
   input  logic [WIDTH-1:0] req_in1_1,
   input  logic [WIDTH-1:0] req_in2_0,
   input  logic [WIDTH-1:0] req_in2_1,
   input  logic [3:0]       req_op_0,
   input  logic [3:0]       req_op_1,
   output logic [WIDTH-1:0] alu_in_1,
   output logic [WIDTH-1:0] alu_in_2,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_bcond,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_bcond,
   output logic             rsp_id,
   output logic             rsp_err,
   output logic [CNT_W-1:0] grant_cnt_0,
   output logic [CNT_W-1:0] grant_cnt_1
);

   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_bcond_q, rsp_bcond_d;
   logic             rsp_id_q, rsp_id_d;
   logic             rsp_err_q, rsp_err_d;
   logic             ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   logic any_valid;
   logic winner;
   logic can_accept;
   logic accept;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0110,
         4'b0011, 4'b0111, 4'b1000: op_legal = 1'b1;
         default:                   op_legal = 1'b0;
      endcase
   endfunction

   always_comb begin
      any_valid  = req_valid_0 | req_valid_1;
      // Contention is resolved by the pointer; a lone requester always wins.
      winner     = (req_valid_0 && req_valid_1) ? ptr_q : req_valid_1;
      can_accept = !reset && (!rsp_valid_q || rsp_ready);
      accept     = any_valid && can_accept;

      req_ready_0 = can_accept && (winner == 1'b0);
      req_ready_1 = can_accept && (winner == 1'b1);

      alu_in_1 = '0;
      alu_in_2 = '0;
      alu_op   = 4'b0000;
      if (any_valid) begin
         alu_in_1 = winner ? req_in1_1 : req_in1_0;
         alu_in_2 = winner ? req_in2_1 : req_in2_0;
         alu_op   = winner ? req_op_1  : req_op_0;
      end
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_bcond_d = rsp_bcond_q;
      rsp_id_d    = rsp_id_q;
      rsp_err_d   = rsp_err_q;
      ptr_d       = ptr_q;
      cnt0_d      = cnt0_q;
      cnt1_d      = cnt1_q;

      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = winner;
         ptr_d       = ~winner;
         if (op_legal(alu_op)) begin
            rsp_data_d  = alu_result;
            rsp_bcond_d = alu_bcond;
            rsp_err_d   = 1'b0;
         end else begin
            rsp_data_d  = '0;
            rsp_bcond_d = 1'b0;
            rsp_err_d   = 1'b1;
         end
         if (winner == 1'b0) begin
            if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
         end else begin
            if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
         end
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_bcond_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         ptr_q       <= 1'b0;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_bcond_q <= rsp_bcond_d;
         rsp_id_q    <= rsp_id_d;
         rsp_err_q   <= rsp_err_d;
         ptr_q       <= ptr_d;
         cnt0_q      <= cnt0_d;
         cnt1_q      <= cnt1_d;
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_bcond   = rsp_bcond_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_err     = rsp_err_q;
   assign grant_cnt_0 = cnt0_q;
   assign grant_cnt_1 = cnt1_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - directed bench for alu_rr_arbiter with a behavioural ALU
// A second instance with 2-bit counters shares all inputs to exercise saturation.
module tb_alu_rr_arbiter;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             req_valid_0, req_valid_1;
   logic             req_ready_0, req_ready_1;
   logic [WIDTH-1:0] req_in1_0, req_in1_1, req_in2_0, req_in2_1;
   logic [3:0]       req_op_0, req_op_1;
   logic [WIDTH-1:0] alu_in_1, alu_in_2;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_result;
   logic             alu_bcond;
   logic             rsp_valid, rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_bcond, rsp_id, rsp_err;
   logic [15:0]      grant_cnt_0, grant_cnt_1;

   logic             s_req_ready_0, s_req_ready_1;
   logic [WIDTH-1:0] s_alu_in_1, s_alu_in_2;
   logic [3:0]       s_alu_op;
   logic             s_rsp_valid;
   logic [WIDTH-1:0] s_rsp_data;
   logic             s_rsp_bcond, s_rsp_id, s_rsp_err;
   logic [1:0]       s_grant_cnt_0, s_grant_cnt_1;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   alu_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
      .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
      .req_in1_0(req_in1_0), .req_in1_1(req_in1_1),
      .req_in2_0(req_in2_0), .req_in2_1(req_in2_1),
      .req_op_0(req_op_0), .req_op_1(req_op_1),
      .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_op(alu_op),
      .alu_result(alu_result), .alu_bcond(alu_bcond),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_bcond(rsp_bcond),
      .rsp_id(rsp_id), .rsp_err(rsp_err),
      .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1)
   );

   alu_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset),
      .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
      .req_ready_0(s_req_ready_0), .req_ready_1(s_req_ready_1),
      .req_in1_0(req_in1_0), .req_in1_1(req_in1_1),
      .req_in2_0(req_in2_0), .req_in2_1(req_in2_1),
      .req_op_0(req_op_0), .req_op_1(req_op_1),
      .alu_in_1(s_alu_in_1), .alu_in_2(s_alu_in_2), .alu_op(s_alu_op),
      .alu_result(alu_result), .alu_bcond(alu_bcond),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(s_rsp_data), .rsp_bcond(s_rsp_bcond),
      .rsp_id(s_rsp_id), .rsp_err(s_rsp_err),
      .grant_cnt_0(s_grant_cnt_0), .grant_cnt_1(s_grant_cnt_1)
   );

   // Reference ALU; illegal codes produce garbage so that zeroing by the DUT is visible.
   function automatic logic [WIDTH-1:0] alu_model(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      case (op)
         4'b0000: alu_model = a & b;
         4'b0001: alu_model = a | b;
         4'b0010: alu_model = a + b;
         4'b0110: alu_model = a - b;
         4'b0011: alu_model = a << b[4:0];
         4'b0111: alu_model = a ^ b;
         4'b1000: alu_model = a >> b[4:0];
         default: alu_model = 32'hDEAD_BEEF;
      endcase
   endfunction

   always_comb begin
      alu_result = alu_model(alu_op, alu_in_1, alu_in_2);
      alu_bcond  = (alu_result == '0);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Requester-side protocol: a stalled request must stay valid and stable until ready.
   logic             pend0 = 1'b0, pend1 = 1'b0;
   logic [WIDTH-1:0] h_in1_0, h_in2_0, h_in1_1, h_in2_1;
   logic [3:0]       h_op_0, h_op_1;
   always @(posedge clk) begin
      if (pend0 && !reset) begin
         vectors++;
         assert (req_valid_0 && req_in1_0 === h_in1_0 && req_in2_0 === h_in2_0 && req_op_0 === h_op_0)
         else begin
            errors++;
            $error("FAIL proto0 observed=%0h expected=%0h", req_op_0, h_op_0);
         end
      end
      if (pend1 && !reset) begin
         vectors++;
         assert (req_valid_1 && req_in1_1 === h_in1_1 && req_in2_1 === h_in2_1 && req_op_1 === h_op_1)
         else begin
            errors++;
            $error("FAIL proto1 observed=%0h expected=%0h", req_op_1, h_op_1);
         end
      end
      pend0   = req_valid_0 && !req_ready_0 && !reset;
      pend1   = req_valid_1 && !req_ready_1 && !reset;
      h_in1_0 = req_in1_0; h_in2_0 = req_in2_0; h_op_0 = req_op_0;
      h_in1_1 = req_in1_1; h_in2_1 = req_in2_1; h_op_1 = req_op_1;
   end

   task automatic post_edge;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      rsp_ready   = 1'b0;
      req_valid_0 = 1'b1; req_in1_0 = 32'd1; req_in2_0 = 32'd1; req_op_0 = 4'b0010;
      req_valid_1 = 1'b1; req_in1_1 = 32'd2; req_in2_1 = 32'd2; req_op_1 = 4'b0010;

      // Reset with both requesters valid
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         chk("rst_ready0", req_ready_0, 0);
         chk("rst_ready1", req_ready_1, 0);
      end
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_bcond", rsp_bcond, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_err", rsp_err, 0);
      chk("rst_cnt0", grant_cnt_0, 0);
      chk("rst_cnt1", grant_cnt_1, 0);

      @(negedge clk);
      reset = 1'b0; req_valid_0 = 1'b0; req_valid_1 = 1'b0; rsp_ready = 1'b1;
      #1;
      chk("idle_alu_in1", alu_in_1, 0);
      chk("idle_alu_op", alu_op, 0);
      post_edge();

      // Single ADD 5+7 from requester 0
      @(negedge clk);
      req_valid_0 = 1'b1; req_in1_0 = 32'd5; req_in2_0 = 32'd7; req_op_0 = 4'b0010;
      #1;
      chk("add_ready0", req_ready_0, 1);
      chk("add_ready1", req_ready_1, 0);
      chk("add_alu_op", alu_op, 4'b0010);
      post_edge();
      chk("add_valid", rsp_valid, 1);
      chk("add_data", rsp_data, 12);
      chk("add_bcond", rsp_bcond, 0);
      chk("add_id", rsp_id, 0);
      chk("add_cnt0", grant_cnt_0, 1);

      // Reset to bring the pointer and counters back to 0
      @(negedge clk);
      req_valid_0 = 1'b0; reset = 1'b1;
      post_edge();
      chk("rst2_valid", rsp_valid, 0);

      // Contention: SUB 9,9 vs XOR F0,0F
      @(negedge clk);
      reset = 1'b0;
      req_valid_0 = 1'b1; req_in1_0 = 32'd9;    req_in2_0 = 32'd9;    req_op_0 = 4'b0110;
      req_valid_1 = 1'b1; req_in1_1 = 32'hF0;   req_in2_1 = 32'h0F;   req_op_1 = 4'b0111;
      for (int i = 0; i < 4; i++) begin
         if (i != 0) @(negedge clk);
         #1;
         chk("cont_ready0", req_ready_0, (i % 2) == 0);
         chk("cont_ready1", req_ready_1, (i % 2) == 1);
         post_edge();
         chk("cont_id", rsp_id, (i % 2) == 1);
         chk("cont_data", rsp_data, ((i % 2) == 1) ? 32'hFF : 32'h0);
         chk("cont_bcond", rsp_bcond, (i % 2) == 0);
      end
      chk("cont_cnt0", grant_cnt_0, 2);
      chk("cont_cnt1", grant_cnt_1, 2);

      // Let the stalled requester 0 finish alone
      @(negedge clk);
      req_valid_1 = 1'b0;
      #1;
      chk("cont_tail_ready0", req_ready_0, 1);
      post_edge();

      // Backpressure: SRL 0x80>>3 from requester 1, then stall with AND pending
      @(negedge clk);
      req_valid_0 = 1'b0;
      req_valid_1 = 1'b1; req_in1_1 = 32'h80; req_in2_1 = 32'd3; req_op_1 = 4'b1000;
      #1;
      chk("srl_ready1", req_ready_1, 1);
      post_edge();
      chk("srl_data", rsp_data, 32'h10);
      chk("srl_id", rsp_id, 1);
      @(negedge clk);
      req_valid_1 = 1'b0; rsp_ready = 1'b0;
      req_valid_0 = 1'b1; req_in1_0 = 32'hC; req_in2_0 = 32'hA; req_op_0 = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         if (i != 0) @(negedge clk);
         #1;
         chk("bp_ready0", req_ready_0, 0);
         post_edge();
         chk("bp_valid", rsp_valid, 1);
         chk("bp_data", rsp_data, 32'h10);
         chk("bp_id", rsp_id, 1);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready0", req_ready_0, 1);
      post_edge();
      chk("bp_next_valid", rsp_valid, 1);
      chk("bp_next_data", rsp_data, 32'h8);
      chk("bp_next_id", rsp_id, 0);

      // Illegal opcode 0101, then a legal ADD clears the error
      @(negedge clk);
      req_in1_0 = 32'd1; req_in2_0 = 32'd2; req_op_0 = 4'b0101;
      post_edge();
      chk("ill_valid", rsp_valid, 1);
      chk("ill_err", rsp_err, 1);
      chk("ill_data", rsp_data, 0);
      chk("ill_bcond", rsp_bcond, 0);
      @(negedge clk);
      req_op_0 = 4'b0010;
      post_edge();
      chk("leg_err", rsp_err, 0);
      chk("leg_data", rsp_data, 3);

      // Reset while a response is pending and the pointer is at 1
      @(negedge clk);
      rsp_ready = 1'b0; reset = 1'b1;
      req_valid_1 = 1'b1; req_in1_1 = 32'd4; req_in2_1 = 32'd4; req_op_1 = 4'b0001;
      #1;
      chk("rstp_ready0", req_ready_0, 0);
      chk("rstp_ready1", req_ready_1, 0);
      post_edge();
      chk("rstp_valid", rsp_valid, 0);
      @(negedge clk);
      reset = 1'b0; rsp_ready = 1'b1;
      #1;
      chk("rstp_ready0_after", req_ready_0, 1);
      chk("rstp_ready1_after", req_ready_1, 0);
      post_edge();
      chk("rstp_id", rsp_id, 0);

      // Saturation on the 2-bit counter instance
      @(negedge clk);
      reset = 1'b1; req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      post_edge();
      @(negedge clk);
      reset = 1'b0; req_valid_1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i != 0) @(negedge clk);
         post_edge();
         chk("sat_cnt1", s_grant_cnt_1, (i < 3) ? i + 1 : 3);
      end
      chk("wide_cnt1", grant_cnt_1, 5);

      @(negedge clk);
      req_valid_1 = 1'b0;
      post_edge();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
